stride_parity_counter: RTL and testbench

Parametrised successor to the team's fixed 8-bit odd counter. Generates odd or even sequences of configurable width and stride, counting up or down, with synchronous load, wrap or saturate on overflow, a terminal-count flag and a wrap/clamp event pulse. It sits as a stimulus/sequence source in datapath and test harnesses where the old odd counter was used.

---
 rtl/stride_parity_counter.sv | 73 +++++++
 tb/tb_stride_parity_counter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/stride_parity_counter.sv
// stride_parity_counter: odd/even sequence counter with stride, direction, load, wrap/saturate
//   clk         rising-edge clock
//   reset       asynchronous active-high reset (cnt_o=RST_VAL, evt_o=0)
//   en_i        advance this cycle
//   load_i      synchronous load, beats en_i
//   load_val_i  load value; its LSB is replaced by parity_i
//   parity_i    1 = odd sequence, 0 = even sequence
//   dir_i       1 = up, 0 = down
//   step_i      stride = 2*step_i; 0 holds
//   sat_i       1 = clamp at bounds, 0 = wrap modulo 2^WIDTH
//   cnt_o       registered count
//   tc_o        count sits at the bound of the current direction
//   evt_o       one-cycle pulse after a wrap or clamp
module stride_parity_counter #(
    parameter int WIDTH = 8,
    parameter int STEP_W = 4,
    parameter logic [WIDTH-1:0] RST_VAL = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              load_i,
    input  logic [WIDTH-1:0]  load_val_i,
    input  logic              parity_i,
    input  logic              dir_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic              sat_i,
    output logic [WIDTH-1:0]  cnt_o,
    output logic              tc_o,
    output logic              evt_o
);
    // wide enough that neither the count plus stride nor the bound plus stride can overflow
    localparam int AW = WIDTH + STEP_W + 1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    logic [WIDTH-1:0] max_v, min_v, nxt;
    logic [AW-1:0] c_ext, s_ext, up_sum;
    logic nxt_evt, edge_hit, over, under;
    // bounds follow the parity of the current count; in the stride branch it equals parity_i
    assign max_v = {{(WIDTH-1){1'b1}}, cnt_o[0]};
    assign min_v = {{(WIDTH-1){1'b0}}, cnt_o[0]};
    assign c_ext = {{(AW-WIDTH){1'b0}}, cnt_o};
    assign s_ext = {{(AW-STEP_W-1){1'b0}}, step_i, 1'b0};
    assign up_sum = c_ext + s_ext;
    assign over = up_sum > {{(AW-WIDTH){1'b0}}, max_v};
    assign under = c_ext < ({{(AW-WIDTH){1'b0}}, min_v} + s_ext);
    assign edge_hit = dir_i ? &cnt_o : ~|cnt_o;
    assign tc_o = dir_i ? cnt_o == max_v : cnt_o == min_v;
    always_comb begin
        nxt = cnt_o;
        nxt_evt = 1'b0;
        if (load_i) begin
            nxt = (load_val_i & ~ONE) | {{(WIDTH-1){1'b0}}, parity_i};
        end else if (en_i && cnt_o[0] != parity_i) begin
            // a realign that would leave the range bounces back when saturating, else wraps naturally
            nxt_evt = edge_hit;
            nxt = (edge_hit && sat_i) ? (dir_i ? cnt_o - ONE : cnt_o + ONE)
                                      : (dir_i ? cnt_o + ONE : cnt_o - ONE);
        end else if (en_i && |step_i) begin
            nxt_evt = dir_i ? over : under;
            nxt = dir_i ? ((over && sat_i) ? max_v : up_sum[WIDTH-1:0])
                        : ((under && sat_i) ? min_v : cnt_o - s_ext[WIDTH-1:0]);
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_o <= RST_VAL;
            evt_o <= 1'b0;
        end else begin
            cnt_o <= nxt;
            evt_o <= nxt_evt;
        end
    end
endmodule

// File: tb/tb_stride_parity_counter.sv
// tb_stride_parity_counter: directed checks of stride_parity_counter against an integer model
module tb_stride_parity_counter;
    logic clk = 0, reset = 1;
    logic ld8 = 0, par8 = 1, dir8 = 1, sat8 = 0, en8 = 0;
    logic [7:0] lv8 = 0;
    logic [3:0] st8 = 0;
    logic ld4 = 0, par4 = 1, dir4 = 1, sat4 = 0, en4 = 0;
    logic [3:0] lv4 = 0, st4 = 0;
    logic [7:0] cnt8;
    logic [3:0] cnt4;
    logic tc8, evt8, tc4, evt4;
    int checks = 0, errors = 0;
    int m8, m4, e8, e4;
    bit started = 0;

    always #5 clk = ~clk;

    stride_parity_counter #(.WIDTH(8), .STEP_W(4), .RST_VAL(8'd1)) dut8 (
        .clk(clk), .reset(reset), .en_i(en8), .load_i(ld8), .load_val_i(lv8),
        .parity_i(par8), .dir_i(dir8), .step_i(st8), .sat_i(sat8),
        .cnt_o(cnt8), .tc_o(tc8), .evt_o(evt8));

    stride_parity_counter #(.WIDTH(4), .STEP_W(4), .RST_VAL(4'd1)) dut4 (
        .clk(clk), .reset(reset), .en_i(en4), .load_i(ld4), .load_val_i(lv4),
        .parity_i(par4), .dir_i(dir4), .step_i(st4), .sat_i(sat4),
        .cnt_o(cnt4), .tc_o(tc4), .evt_o(evt4));

    // next count and event from the rules: range 0..2^w-1, parity bounds, realign first, then stride
    task automatic model(input int w, input int cnt, input bit ld, input int lv, input bit par,
                         input bit dir, input int st, input bit sat, input bit en,
                         output int nc, output int ne);
        int m, mx, mn, t, s;
        m = 1 << w;
        mx = m - 2 + par;
        mn = par;
        s = 2 * st;
        nc = cnt;
        ne = 0;
        if (ld) begin
            nc = (lv / 2) * 2 + par;
        end else if (en && (cnt % 2) != par) begin
            t = dir ? cnt + 1 : cnt - 1;
            if (t >= m || t < 0) begin
                ne = 1;
                nc = sat ? (dir ? cnt - 1 : cnt + 1) : ((t % m) + m) % m;
            end else nc = t;
        end else if (en && st != 0) begin
            t = dir ? cnt + s : cnt - s;
            if (dir ? t > mx : t < mn) begin
                ne = 1;
                nc = sat ? (dir ? mx : mn) : ((t % m) + m) % m;
            end else nc = t;
        end
    endtask

    function automatic int tc_model(input int w, input int cnt, input bit dir);
        return dir ? int'(cnt == (1 << w) - 2 + cnt % 2) : int'(cnt == cnt % 2);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m8 = 1; e8 = 0; m4 = 1; e4 = 0;
        end else begin
            model(8, m8, ld8, int'(lv8), par8, dir8, int'(st8), sat8, en8, m8, e8);
            model(4, m4, ld4, int'(lv4), par4, dir4, int'(st4), sat4, en4, m4, e4);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("model cnt8", int'(cnt8), m8);
            chk("model evt8", int'(evt8), e8);
            chk("model tc8", int'(tc8), tc_model(8, m8, dir8));
            chk("model cnt4", int'(cnt4), m4);
            chk("model evt4", int'(evt4), e4);
            chk("model tc4", int'(tc4), tc_model(4, m4, dir4));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        started = 1;
        repeat (2) @(posedge clk);
        #2;
        reset = 0;
        chk("reset cnt", int'(cnt8), 1);
        chk("reset evt", int'(evt8), 0);
        // odd up stride 2 through the top and wrap
        par8 = 1; dir8 = 1; st8 = 1; en8 = 1; sat8 = 0;
        repeat (127) cyc();
        chk("t1 at 255", int'(cnt8), 255);
        chk("t1 tc", int'(tc8), 1);
        chk("t1 no evt", int'(evt8), 0);
        cyc();
        chk("t1 wrap cnt", int'(cnt8), 1);
        chk("t1 wrap evt", int'(evt8), 1);
        cyc();
        chk("t1 after wrap", int'(cnt8), 3);
        chk("t1 evt clears", int'(evt8), 0);
        // load then count down by 6
        ld8 = 1; lv8 = 8'h40; par8 = 1; en8 = 0;
        cyc();
        chk("t2 load", int'(cnt8), 8'h41);
        ld8 = 0; en8 = 1; dir8 = 0; st8 = 3;
        cyc();
        chk("t2 down1", int'(cnt8), 8'h3B);
        cyc();
        chk("t2 down2", int'(cnt8), 8'h35);
        ld8 = 1; lv8 = 8'h80;
        cyc();
        chk("t2 load wins", int'(cnt8), 8'h81);
        // even saturate up, clamp, then wrap
        ld8 = 1; lv8 = 8'd248; par8 = 0;
        cyc();
        chk("t3 load 248", int'(cnt8), 248);
        ld8 = 0; en8 = 1; dir8 = 1; st8 = 4; sat8 = 1;
        cyc();
        chk("t3 clamp cnt", int'(cnt8), 254);
        chk("t3 clamp evt", int'(evt8), 1);
        cyc();
        chk("t3 reclamp cnt", int'(cnt8), 254);
        chk("t3 reclamp evt", int'(evt8), 1);
        sat8 = 0; st8 = 1;
        cyc();
        chk("t3 wrap cnt", int'(cnt8), 0);
        chk("t3 wrap evt", int'(evt8), 1);
        // realign
        ld8 = 1; lv8 = 8'd10; par8 = 0;
        cyc();
        ld8 = 0; par8 = 1; dir8 = 1; st8 = 1; en8 = 1; sat8 = 0;
        cyc();
        chk("t4 realign", int'(cnt8), 11);
        chk("t4 realign evt", int'(evt8), 0);
        cyc();
        chk("t4 stride", int'(cnt8), 13);
        ld8 = 1; lv8 = 8'd0; par8 = 0;
        cyc();
        ld8 = 0; par8 = 1; dir8 = 0; sat8 = 1;
        cyc();
        chk("t4 bounce cnt", int'(cnt8), 1);
        chk("t4 bounce evt", int'(evt8), 1);
        // async reset between edges
        ld8 = 1; lv8 = 8'h56; par8 = 1; sat8 = 0;
        cyc();
        chk("t5 load 57", int'(cnt8), 8'h57);
        ld8 = 0; dir8 = 1; st8 = 1; en8 = 1;
        #1 reset = 1;
        #1;
        chk("t5 async cnt", int'(cnt8), 1);
        chk("t5 async evt", int'(evt8), 0);
        cyc();
        reset = 0;
        cyc();
        chk("t5 resume", int'(cnt8), 3);
        // 4-bit instance
        ld4 = 1; lv4 = 4'd2; par4 = 1;
        cyc();
        chk("t6 load 3", int'(cnt4), 3);
        ld4 = 0; en4 = 1; dir4 = 1; st4 = 7; sat4 = 0;
        cyc();
        chk("t6 wrap cnt", int'(cnt4), 1);
        chk("t6 wrap evt", int'(evt4), 1);
        st4 = 0;
        cyc();
        chk("t6 hold cnt", int'(cnt4), 1);
        chk("t6 hold evt", int'(evt4), 0);
        st4 = 7; sat4 = 1;
        cyc();
        chk("t6 to max", int'(cnt4), 15);
        chk("t6 tc", int'(tc4), 1);
        cyc();
        chk("t6 clamp cnt", int'(cnt4), 15);
        chk("t6 clamp evt", int'(evt4), 1);
        en4 = 0; en8 = 0;
        repeat (2) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
